// File: rtl/vend_pkg.sv
// Shared types and default sizes for the coin accumulator slice.
// No logic here: state encoding, credit width and the credit ceiling.
package vend_pkg;

  localparam int CREDIT_W_DEF   = 4;
  localparam int MAX_CREDIT_DEF = 15;

  typedef logic [CREDIT_W_DEF-1:0] credit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

endpackage

// File: rtl/vend_timeout_timer.sv
// Inactivity down-counter: reload wins over enable, saturates at zero.
// expired reflects the registered count (zero-cycle decode, no backpressure).
module vend_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (reload) begin
      count <= TW'(TIMEOUT_CYCLES);
    end else if (enable && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/coin_accumulator.sv
// Coin credit accumulator with vend and change req/ack handshakes.
// All outputs registered (one cycle after the causing edge); handshakes hold until ack.
module coin_accumulator
  import vend_pkg::*;
#(
  parameter int CREDIT_W       = CREDIT_W_DEF,
  parameter int MAX_CREDIT     = MAX_CREDIT_DEF,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [CREDIT_W-1:0] coin_value,
  input  logic [CREDIT_W-1:0] coffee_price,
  input  logic                cancel,
  output logic                coin_accept,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_value,
  input  logic                change_ack,
  output logic                led_yellow,
  output logic                led_green
);

  state_t              state;
  logic [CREDIT_W-1:0] price_q;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  logic                vend_ready;
  logic                accept_now;
  logic                tmr_enable;
  logic                expired;

  // A coin is only taken when no higher-priority COLLECT event fires this cycle.
  always_comb begin
    sum        = {1'b0, credit} + {1'b0, coin_value};
    coin_ok    = coin_valid && (coin_value != '0) &&
                 (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    vend_ready = (coffee_price != '0) && (credit >= coffee_price);
    accept_now = 1'b0;
    case (state)
      IDLE:    accept_now = coin_ok;
      COLLECT: accept_now = coin_ok && !cancel && !expired && !vend_ready;
      default: accept_now = 1'b0;
    endcase
    tmr_enable = (state == COLLECT) && !accept_now;
  end

  vend_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .reload (accept_now),
    .enable (tmr_enable),
    .expired(expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      credit       <= '0;
      price_q      <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      vend_req     <= 1'b0;
      change_valid <= 1'b0;
      change_value <= '0;
      led_yellow   <= 1'b0;
      led_green    <= 1'b0;
    end else begin
      coin_accept <= accept_now;
      coin_reject <= coin_valid && !accept_now;
      case (state)
        IDLE: begin
          if (accept_now) begin
            credit     <= sum[CREDIT_W-1:0];
            state      <= COLLECT;
            led_yellow <= 1'b1;
          end
        end
        COLLECT: begin
          if (cancel || expired) begin
            state        <= CHANGE;
            change_valid <= 1'b1;
            change_value <= credit;
            led_yellow   <= 1'b0;
          end else if (vend_ready) begin
            state      <= VEND;
            price_q    <= coffee_price;
            vend_req   <= 1'b1;
            led_yellow <= 1'b0;
            led_green  <= 1'b1;
          end else if (accept_now) begin
            credit <= sum[CREDIT_W-1:0];
          end
        end
        VEND: begin
          if (vend_ack) begin
            vend_req  <= 1'b0;
            led_green <= 1'b0;
            // Remaining credit is exactly what is owed back, so CHANGE shows credit == change_value.
            if (credit != price_q) begin
              state        <= CHANGE;
              change_valid <= 1'b1;
              change_value <= credit - price_q;
              credit       <= credit - price_q;
            end else begin
              state  <= IDLE;
              credit <= '0;
            end
          end
        end
        CHANGE: begin
          if (change_ack) begin
            state        <= IDLE;
            change_valid <= 1'b0;
            change_value <= '0;
            credit       <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural model that tracks credit, phase and cycles since the last accepted coin.
module tb_coin_accumulator;

  localparam int TO  = 1000;
  localparam int MAX = 15;

  logic       clk, rst_n;
  logic       coin_valid, cancel, vend_ack, change_ack;
  logic [3:0] coin_value, coffee_price;
  logic       coin_accept, coin_reject, vend_req, change_valid, led_yellow, led_green;
  logic [3:0] credit, change_value;

  int total = 0;
  int bad   = 0;

  coin_accumulator #(.CREDIT_W(4), .MAX_CREDIT(MAX), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .coffee_price(coffee_price), .cancel(cancel),
    .coin_accept(coin_accept), .coin_reject(coin_reject),
    .credit(credit), .vend_req(vend_req), .vend_ack(vend_ack),
    .change_valid(change_valid), .change_value(change_value),
    .change_ack(change_ack), .led_yellow(led_yellow), .led_green(led_green)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [13:0] dut_vec;
  assign dut_vec = {coin_accept, coin_reject, credit, vend_req, change_valid,
                    change_value, led_yellow, led_green};

  // Behavioural reference
  typedef enum {M_IDLE, M_COLLECT, M_VEND, M_CHANGE} mphase_t;
  mphase_t m_phase;
  int      m_credit, m_price, m_change, m_quiet;
  bit      m_acc, m_rej;

  task automatic model_reset();
    m_phase = M_IDLE; m_credit = 0; m_price = 0; m_change = 0; m_quiet = 0;
    m_acc = 0; m_rej = 0;
  endtask

  task automatic model_step();
    bit took;
    int tot;
    took = 0;
    tot  = m_credit + int'(coin_value);
    case (m_phase)
      M_IDLE: begin
        if (coin_valid && coin_value != 0 && tot <= MAX) begin
          took = 1; m_credit = tot; m_phase = M_COLLECT; m_quiet = 0;
        end
      end
      M_COLLECT: begin
        if (cancel || m_quiet >= TO) begin
          m_change = m_credit; m_phase = M_CHANGE;
        end else if (coffee_price != 0 && m_credit >= int'(coffee_price)) begin
          m_price = int'(coffee_price); m_phase = M_VEND;
        end else if (coin_valid && coin_value != 0 && tot <= MAX) begin
          took = 1; m_credit = tot; m_quiet = 0;
        end else begin
          m_quiet++;
        end
      end
      M_VEND: begin
        if (vend_ack) begin
          if (m_credit > m_price) begin
            m_change = m_credit - m_price; m_credit = m_change; m_phase = M_CHANGE;
          end else begin
            m_credit = 0; m_phase = M_IDLE;
          end
        end
      end
      M_CHANGE: begin
        if (change_ack) begin
          m_credit = 0; m_change = 0; m_phase = M_IDLE;
        end
      end
      default: m_phase = M_IDLE;
    endcase
    m_acc = took;
    m_rej = coin_valid && !took;
  endtask

  function automatic logic [13:0] model_vec();
    return {m_acc, m_rej, 4'(m_credit), m_phase == M_VEND, m_phase == M_CHANGE,
            4'(m_change), m_phase == M_COLLECT, m_phase == M_VEND};
  endfunction

  task automatic tick(input logic cv, input logic [3:0] cval, input logic can,
                      input logic va, input logic ca);
    @(negedge clk);
    coin_valid = cv; coin_value = cval; cancel = can; vend_ack = va; change_ack = ca;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; coin_valid = 0; coin_value = 0; coffee_price = 0;
    cancel = 0; vend_ack = 0; change_ack = 0;
    model_reset();
    #3;
    total++;
    if (dut_vec !== 14'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", dut_vec);
    end
    @(negedge clk); rst_n = 1'b1;
    tick(0, 0, 0, 0, 0);
    total++;
    if (dut_vec !== 14'h0) begin
      bad++; $display("FAIL reset_idle got=%h want=0", dut_vec);
    end
  endtask

  task automatic test_exact_pay();
    coffee_price = 4'd6;
    tick(1, 4'd2, 0, 0, 0);
    total++;
    if ({coin_accept, coin_reject, credit, led_yellow} !== {1'b1, 1'b0, 4'd2, 1'b1}) begin
      bad++; $display("FAIL exact_coin1 got=%b want=%b",
                      {coin_accept, coin_reject, credit, led_yellow}, {1'b1, 1'b0, 4'd2, 1'b1});
    end
    tick(1, 4'd4, 0, 0, 0);
    total++;
    if ({coin_accept, credit, vend_req} !== {1'b1, 4'd6, 1'b0}) begin
      bad++; $display("FAIL exact_coin2 got=%b want=%b", {coin_accept, credit, vend_req}, {1'b1, 4'd6, 1'b0});
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    total++;
    if ({vend_req, led_green, led_yellow, coin_accept} !== 4'b1100) begin
      bad++; $display("FAIL exact_vend_hold got=%b want=1100", {vend_req, led_green, led_yellow, coin_accept});
    end
    tick(0, 0, 0, 1, 0);
    total++;
    if ({vend_req, change_valid, credit, led_green} !== 7'b0) begin
      bad++; $display("FAIL exact_done got=%b want=0", {vend_req, change_valid, credit, led_green});
    end
  endtask

  task automatic test_overpay();
    coffee_price = 4'd5;
    tick(1, 4'd4, 0, 0, 0);
    tick(1, 4'd4, 0, 0, 0);
    total++;
    if (credit !== 4'd8) begin
      bad++; $display("FAIL overpay_credit got=%0d want=8", credit);
    end
    tick(0, 0, 0, 0, 0);
    total++;
    if (vend_req !== 1'b1) begin
      bad++; $display("FAIL overpay_vend got=%b want=1", vend_req);
    end
    tick(0, 0, 0, 1, 0);
    total++;
    if ({vend_req, change_valid, change_value} !== {1'b0, 1'b1, 4'd3}) begin
      bad++; $display("FAIL overpay_change got=%b want=%b", {vend_req, change_valid, change_value}, {1'b0, 1'b1, 4'd3});
    end
    tick(1, 4'd1, 0, 0, 0);
    total++;
    if ({coin_reject, change_valid, change_value} !== {1'b1, 1'b1, 4'd3}) begin
      bad++; $display("FAIL overpay_hold got=%b want=%b", {coin_reject, change_valid, change_value}, {1'b1, 1'b1, 4'd3});
    end
    tick(0, 0, 0, 0, 1);
    total++;
    if ({change_valid, credit} !== 5'b0) begin
      bad++; $display("FAIL overpay_ack got=%b want=0", {change_valid, credit});
    end
  endtask

  task automatic test_overflow();
    coffee_price = 4'd15;
    tick(1, 4'd8, 0, 0, 0);
    tick(1, 4'd5, 0, 0, 0);
    total++;
    if (credit !== 4'd13) begin
      bad++; $display("FAIL overflow_setup got=%0d want=13", credit);
    end
    tick(1, 4'd4, 0, 0, 0);
    total++;
    if ({coin_accept, coin_reject, credit} !== {1'b0, 1'b1, 4'd13}) begin
      bad++; $display("FAIL overflow_reject got=%b want=%b", {coin_accept, coin_reject, credit}, {1'b0, 1'b1, 4'd13});
    end
    tick(1, 4'd0, 0, 0, 0);
    total++;
    if ({coin_accept, coin_reject} !== 2'b01) begin
      bad++; $display("FAIL zero_coin got=%b want=01", {coin_accept, coin_reject});
    end
    tick(1, 4'd2, 0, 0, 0);
    total++;
    if ({coin_accept, credit} !== {1'b1, 4'd15}) begin
      bad++; $display("FAIL overflow_fill got=%b want=%b", {coin_accept, credit}, {1'b1, 4'd15});
    end
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    total++;
    if ({vend_req, change_valid, credit} !== 6'b0) begin
      bad++; $display("FAIL overflow_vend got=%b want=0", {vend_req, change_valid, credit});
    end
  endtask

  task automatic test_cancel();
    coffee_price = 4'd10;
    tick(0, 0, 1, 0, 0);
    total++;
    if ({led_yellow, change_valid} !== 2'b00) begin
      bad++; $display("FAIL cancel_idle got=%b want=00", {led_yellow, change_valid});
    end
    tick(1, 4'd3, 0, 0, 0);
    tick(1, 4'd2, 1, 0, 0);
    total++;
    if ({coin_accept, coin_reject, change_valid, change_value, led_yellow} !== {1'b0, 1'b1, 1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL cancel_coin got=%b want=%b",
                      {coin_accept, coin_reject, change_valid, change_value, led_yellow}, {1'b0, 1'b1, 1'b1, 4'd3, 1'b0});
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_timeout();
    coffee_price = 4'd0;
    tick(1, 4'd2, 0, 0, 0);
    for (int j = 1; j <= TO + 1; j++) begin
      tick(0, 0, 0, 0, 0);
      total++;
      if (j <= TO) begin
        if (change_valid !== 1'b0) begin
          bad++; $display("FAIL timeout_early cycle=%0d got=%b want=0", j, change_valid);
        end
      end else if ({change_valid, change_value, led_yellow} !== {1'b1, 4'd2, 1'b0}) begin
        bad++; $display("FAIL timeout_fire got=%b want=%b", {change_valid, change_value, led_yellow}, {1'b1, 4'd2, 1'b0});
      end
    end
    tick(0, 0, 0, 0, 1);
    tick(1, 4'd2, 0, 0, 0);
    for (int j = 1; j < TO; j++) tick(0, 0, 0, 0, 0);
    tick(1, 4'd1, 0, 0, 0);
    total++;
    if ({coin_accept, credit, change_valid} !== {1'b1, 4'd3, 1'b0}) begin
      bad++; $display("FAIL timeout_reload_coin got=%b want=%b", {coin_accept, credit, change_valid}, {1'b1, 4'd3, 1'b0});
    end
    for (int j = 1; j <= TO + 1; j++) begin
      tick(0, 0, 0, 0, 0);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL timeout_reload cycle=%0d got=%h want=%h", j, dut_vec, model_vec());
      end
    end
    total++;
    if ({change_valid, change_value} !== {1'b1, 4'd3}) begin
      bad++; $display("FAIL timeout_reload_fire got=%b want=%b", {change_valid, change_value}, {1'b1, 4'd3});
    end
    tick(0, 0, 0, 0, 1);
  endtask

  task automatic test_reset_mid_vend();
    coffee_price = 4'd4;
    tick(1, 4'd4, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    total++;
    if (vend_req !== 1'b1) begin
      bad++; $display("FAIL midvend_setup got=%b want=1", vend_req);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (dut_vec !== 14'h0) begin
      bad++; $display("FAIL midvend_async got=%h want=0", dut_vec);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 1, 0);
    total++;
    if (dut_vec !== 14'h0) begin
      bad++; $display("FAIL midvend_late_ack got=%h want=0", dut_vec);
    end
  endtask

  task automatic test_random();
    logic       cv, can, va, ca;
    logic [3:0] cval;
    for (int i = 0; i < 600; i++) begin
      if (m_phase == M_IDLE && $urandom_range(7, 0) == 0) coffee_price = 4'($urandom_range(15, 0));
      cv   = ($urandom_range(9, 0) < 4);
      cval = 4'($urandom_range(15, 0));
      can  = ($urandom_range(24, 0) == 0);
      va   = ($urandom_range(3, 0) == 0);
      ca   = ($urandom_range(3, 0) == 0);
      tick(cv, cval, can, va, ca);
      total++;
      if (dut_vec !== model_vec()) begin
        bad++; $display("FAIL random cycle=%0d got=%h want=%h", i, dut_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_exact_pay();
    test_overpay();
    test_overflow();
    test_cancel();
    test_timeout();
    test_reset_mid_vend();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
